// File: rtl/dffe_write_arbiter_pkg.sv
// Shared definitions for the round-robin DFFE write arbiter: FSM state
// encodings and the width helper used to size the pointer and lock counter.
package dffe_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2(input int v);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << k) < v) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dffe_write_arbiter_bank.sv
// Enable-gated register bank shared by all requesters: loads D when EN is
// high, otherwise holds; synchronous reset clears it.
module dffe_bank #(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= '0;
        end else if (EN) begin
            r_q <= D;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/dffe_write_arbiter.sv
// Round-robin arbiter sharing one DFFE register bank between N requesters,
// with an optional bounded lock that lets a winner hold the bank for a burst.
module dffe_write_arbiter
    import dffe_write_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int WIDTH    = 2,
    parameter int MAX_LOCK = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N-1:0]       REQ,
    input  logic [N-1:0]       LOCK,
    input  logic [N*WIDTH-1:0] D_IN,
    output logic [N-1:0]       GNT,
    output logic               EN,
    output logic [WIDTH-1:0]   D,
    output logic [WIDTH-1:0]   Q
);

    localparam int PTR_W = clog2(N);
    localparam int CNT_W = clog2(MAX_LOCK + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_idx;
    logic [PTR_W-1:0]   w_idx_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_ptr_inc;
    logic [PTR_W-1:0]   w_arb_base;
    logic [PTR_W-1:0]   w_arb_idx;
    logic               w_arb_found;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [N-1:0]       r_gnt;
    logic [N-1:0]       w_gnt_nxt;
    logic               w_cur_req;
    logic               w_cur_lock;
    logic               w_release;
    logic [WIDTH-1:0]   w_d;

    function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base,
                                                  input int k);
        int j;
        j = (int'(base) + k) % N;
        return PTR_W'(j);
    endfunction

    assign w_cur_req  = REQ[r_idx];
    assign w_cur_lock = LOCK[r_idx];
    assign w_ptr_inc  = (r_idx == PTR_W'(N - 1)) ? '0 : r_idx + 1'b1;

    // A release re-arbitrates in the same edge, scanning from the advanced pointer.
    assign w_arb_base = (r_state == ST_IDLE) ? r_ptr : w_ptr_inc;

    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_arb_found && REQ[scan_idx(w_arb_base, k)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = scan_idx(w_arb_base, k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_state_nxt = ST_GRANT;
                    w_idx_nxt   = w_arb_idx;
                end
            end
            ST_GRANT: begin
                if (w_cur_req && w_cur_lock) begin
                    w_state_nxt = ST_LOCKED;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_release = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!w_cur_req || !w_cur_lock || (r_cnt == CNT_W'(MAX_LOCK))) begin
                    w_release = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_release) begin
            w_ptr_nxt = w_ptr_inc;
            w_cnt_nxt = '0;
            if (w_arb_found) begin
                w_state_nxt = ST_GRANT;
                w_idx_nxt   = w_arb_idx;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end

        w_gnt_nxt = '0;
        if (w_state_nxt != ST_IDLE) begin
            w_gnt_nxt[w_idx_nxt] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // Grant is one-hot or zero, so OR-ing the masked slices selects the winner.
    always_comb begin
        w_d = '0;
        for (int i = 0; i < N; i++) begin
            if (r_gnt[i]) begin
                w_d = w_d | D_IN[i*WIDTH +: WIDTH];
            end
        end
    end

    assign GNT = r_gnt;
    assign EN  = |(r_gnt & REQ);
    assign D   = w_d;

    dffe_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .CLK(CLK),
        .RST(RST),
        .EN (EN),
        .D  (w_d),
        .Q  (Q)
    );

endmodule

// File: tb/tb_dffe_write_arbiter.sv
// Bench for dffe_write_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an ownership model.
module tb_dffe_write_arbiter;

    localparam int N        = 4;
    localparam int WIDTH    = 2;
    localparam int MAX_LOCK = 8;

    logic               CLK = 1'b0;
    logic               RST;
    logic [N-1:0]       REQ;
    logic [N-1:0]       LOCK;
    logic [N*WIDTH-1:0] D_IN;
    logic [N-1:0]       GNT;
    logic               EN;
    logic [WIDTH-1:0]   D;
    logic [WIDTH-1:0]   Q;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: who owns the bank, how long it has held it, where the scan starts, bank value.
    int               m_owner = -1;
    int               m_held  = 0;
    int               m_ptr   = 0;
    logic [WIDTH-1:0] m_q     = '0;

    always #5 CLK = ~CLK;

    dffe_write_arbiter #(
        .N(N), .WIDTH(WIDTH), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK), .D_IN(D_IN),
        .GNT(GNT), .EN(EN), .D(D), .Q(Q)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int base);
        for (int k = 0; k < N; k++) begin
            if (req[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic exp_en();
        return (m_owner >= 0) && REQ[m_owner];
    endfunction

    function automatic logic [WIDTH-1:0] exp_d();
        if (m_owner < 0) return '0;
        return D_IN[m_owner*WIDTH +: WIDTH];
    endfunction

    // An owner holds at most MAX_LOCK+1 consecutive cycles; any release hands
    // the scan start to the next index and picks a new owner immediately.
    task automatic model_update();
        if (RST) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_q     = '0;
        end else if (m_owner >= 0) begin
            if (REQ[m_owner]) m_q = D_IN[m_owner*WIDTH +: WIDTH];
            if (REQ[m_owner] && LOCK[m_owner] && m_held <= MAX_LOCK) begin
                m_held++;
            end else begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick(REQ, m_ptr);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end
        end else begin
            m_owner = pick(REQ, m_ptr);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end
    endtask

    task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] l,
                          input logic [N*WIDTH-1:0] d, input logic rs);
        REQ  = r;
        LOCK = l;
        D_IN = d;
        RST  = rs;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("gnt", GNT, exp_gnt());
                check("en", EN, exp_en());
                check("d", D, exp_d());
                check("q", Q, m_q);
                check("gnt_onehot0", $onehot0(GNT), 1);
            end
        end
    end

    logic [N-1:0]     rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [WIDTH-1:0] rr_q [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b10};

    initial begin
        set_in('0, '0, '0, 1'b1);
        tick();
        chk_en = 1'b1;
        @(negedge CLK);
        check("rst_gnt", GNT, 0);
        check("rst_en", EN, 0);
        check("rst_q", Q, 0);
        tick();
        set_in('0, '0, '0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            check("idle_gnt", GNT, 0);
            check("idle_q", Q, 0);
            tick();
        end

        // Single request from requester 2 with data 11.
        set_in(4'b0100, '0, 8'h30, 1'b0);
        @(negedge CLK);
        check("single_t_gnt", GNT, 0);
        tick();
        @(negedge CLK);
        check("single_gnt", GNT, 4'b0100);
        check("single_en", EN, 1);
        check("single_d", D, 2'b11);
        tick();
        set_in('0, '0, 8'h30, 1'b0);
        @(negedge CLK);
        check("single_q", Q, 2'b11);
        check("single_drop_en", EN, 0);
        tick();
        @(negedge CLK);
        check("single_idle_gnt", GNT, 0);
        check("single_hold_q", Q, 2'b11);
        tick();

        // Round robin over all four requesters.
        set_in('0, '0, '0, 1'b1);
        tick();
        set_in(4'b1111, '0, 8'h9E, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("rr_gnt", GNT, rr_g[k]);
            if (k > 0) check("rr_q", Q, rr_q[k]);
            tick();
        end

        // Lock bound: requester 0 holds for 1 + MAX_LOCK cycles.
        set_in('0, '0, '0, 1'b1);
        tick();
        set_in(4'b0011, 4'b0001, 8'h06, 1'b0);
        tick();
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            check("lock_hold_gnt", GNT, 4'b0001);
            tick();
        end
        @(negedge CLK);
        check("lock_release_gnt", GNT, 4'b0010);
        tick();

        // Requester 1 drops its request in its granted cycle.
        set_in('0, '0, '0, 1'b1);
        tick();
        set_in(4'b0001, '0, 8'h07, 1'b0);
        tick();
        set_in(4'b0011, '0, 8'h07, 1'b0);
        @(negedge CLK);
        check("drop_pre_gnt", GNT, 4'b0001);
        check("drop_pre_en", EN, 1);
        tick();
        set_in('0, '0, 8'h07, 1'b0);
        @(negedge CLK);
        check("drop_gnt", GNT, 4'b0010);
        check("drop_en", EN, 0);
        check("drop_q", Q, 2'b11);
        tick();
        @(negedge CLK);
        check("drop_idle_gnt", GNT, 0);
        check("drop_hold_q", Q, 2'b11);
        tick();

        // Reset while locked.
        set_in('0, '0, '0, 1'b1);
        tick();
        set_in(4'b0001, 4'b0001, 8'h01, 1'b0);
        tick();
        @(negedge CLK);
        check("ml_gnt", GNT, 4'b0001);
        tick();
        set_in(4'b0001, 4'b0001, 8'h01, 1'b1);
        @(negedge CLK);
        check("ml_locked_gnt", GNT, 4'b0001);
        check("ml_locked_q", Q, 2'b01);
        tick();
        set_in(4'b1010, '0, 8'h01, 1'b0);
        @(negedge CLK);
        check("ml_rst_gnt", GNT, 0);
        check("ml_rst_q", Q, 0);
        check("ml_rst_en", EN, 0);
        tick();
        @(negedge CLK);
        check("ml_first_win", GNT, 4'b0010);
        tick();

        // Randomized traffic; inputs sometimes held to let locks run to the bound.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) != 0) begin
                set_in(N'($urandom & $urandom | $urandom_range(0, 1)),
                       N'($urandom | $urandom),
                       (N*WIDTH)'($urandom),
                       ($urandom_range(0, 63) == 0));
            end else begin
                RST = 1'b0;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
